timeout_scheduler: RTL and testbench

TIMEOUT_SCHEDULER -- requirements
Module: timeout_scheduler

---
 rtl/timeout_scheduler_pkg.sv | 19 +
 rtl/timeout_scheduler_rr_arbiter.sv | 34 +++
 rtl/timeout_scheduler.sv | 118 +++++++++++
 tb/tb_timeout_scheduler.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timeout_scheduler_pkg.sv
// Shared types and default sizing for the timeout scheduler slice.
// State encoding plus default requester count and counter width.
package timeout_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_CW   = 4;

    // Width of an index into NREQ requesters (at least 1 bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timeout_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner
// and wraps, so the previous owner has the lowest priority.
module rr_arbiter
    import timeout_scheduler_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int IW   = idx_width(DEFAULT_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index
);

    logic found;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int cand;
            cand = (int'(last) + k) % NREQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/timeout_scheduler.sv
// Shared timeout timer granted round-robin to NREQ requesters.
// Optional macro TIMEOUT_SCHEDULER_ABORT_EN: owner dropping req aborts its run.
module timeout_scheduler
    import timeout_scheduler_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int CW   = DEFAULT_CW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] dur,
    input  logic               tick,
    output logic [NREQ-1:0]    gnt,
    output logic [CW-1:0]      count,
    output logic               busy,
    output logic [NREQ-1:0]    done_pulse
);

    localparam int IW = idx_width(NREQ);

    state_t          state;
    logic [IW-1:0]   win_q;
    logic [IW-1:0]   last_q;
    logic [CW-1:0]   dur_q;
    logic [NREQ-1:0] arb_grant;
    logic [IW-1:0]   arb_index;
    logic [CW-1:0]   dur_sel;
    logic            abort_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .last  (last_q),
        .grant (arb_grant),
        .index (arb_index)
    );

    always_comb begin
        dur_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_index == IW'(i)) begin
                dur_sel = dur[i*CW +: CW];
            end
        end
    end

`ifdef TIMEOUT_SCHEDULER_ABORT_EN
    assign abort_hit = ~req[win_q];
`else
    assign abort_hit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done_pulse <= '0;
            dur_q      <= '0;
            win_q      <= '0;
            last_q     <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    done_pulse <= '0;
                    count      <= '0;
                    if (|req) begin
                        state <= RUN;
                        gnt   <= arb_grant;
                        win_q <= arb_index;
                        dur_q <= dur_sel;
                        busy  <= 1'b1;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort_hit) begin
                        state  <= IDLE;
                        gnt    <= '0;
                        count  <= '0;
                        busy   <= 1'b0;
                        last_q <= win_q;
                    end else if (count == dur_q) begin
                        // Equality is tested before the increment, so dur_q=0 exits at once.
                        state      <= DONE;
                        done_pulse <= gnt;
                    end else if (tick) begin
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    gnt        <= '0;
                    count      <= '0;
                    busy       <= 1'b0;
                    done_pulse <= '0;
                    last_q     <= win_q;
                end
                default: begin
                    state      <= IDLE;
                    gnt        <= '0;
                    count      <= '0;
                    busy       <= 1'b0;
                    done_pulse <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timeout_scheduler.sv
// Self-checking bench for timeout_scheduler: directed scenarios plus random
// traffic compared every cycle against a transaction-level reference model.
module tb_timeout_scheduler;

    localparam int NREQ = 4;
    localparam int CW   = 4;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] dur;
    logic               tick;
    logic [NREQ-1:0]    gnt;
    logic [CW-1:0]      count;
    logic               busy;
    logic [NREQ-1:0]    done_pulse;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a run record (owner, limit, elapsed) plus a pending pulse.
    int m_owner;
    int m_limit;
    int m_elapsed;
    int m_last;
    bit m_running;
    bit m_finishing;

    timeout_scheduler #(.NREQ(NREQ), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .dur        (dur),
        .tick       (tick),
        .gnt        (gnt),
        .count      (count),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_running   = 1'b0;
        m_finishing = 1'b0;
        m_owner     = 0;
        m_limit     = 0;
        m_elapsed   = 0;
        m_last      = NREQ - 1;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] d, input logic t);
        bit abort_en;
`ifdef TIMEOUT_SCHEDULER_ABORT_EN
        abort_en = 1'b1;
`else
        abort_en = 1'b0;
`endif
        if (m_finishing) begin
            m_finishing = 1'b0;
            m_last      = m_owner;
        end else if (m_running) begin
            if (abort_en && !r[m_owner]) begin
                m_running = 1'b0;
                m_last    = m_owner;
            end else if (m_elapsed == m_limit) begin
                m_running   = 1'b0;
                m_finishing = 1'b1;
            end else if (t) begin
                m_elapsed++;
            end
        end else if (r != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int i;
                i = (m_last + k) % NREQ;
                if (!m_running && r[i]) begin
                    m_running = 1'b1;
                    m_owner   = i;
                    m_limit   = int'(d[i*CW +: CW]);
                    m_elapsed = 0;
                end
            end
        end
    endtask

    task automatic compare_model();
        bit active;
        active = m_running || m_finishing;
        check("gnt",   32'(gnt),        active ? (32'd1 << m_owner) : 32'd0);
        check("count", 32'(count),      active ? 32'(m_elapsed) : 32'd0);
        check("busy",  32'(busy),       32'(active));
        check("done",  32'(done_pulse), m_finishing ? (32'd1 << m_owner) : 32'd0);
    endtask

    // Drive inputs, let one posedge pass, then compare on the falling edge.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*CW-1:0] d, input logic t);
        req  = r;
        dur  = d;
        tick = t;
        @(posedge clk);
        model_edge(r, d, t);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        dur   = '0;
        tick  = 1'b0;
        #1;
        model_reset();
        compare_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Random background durations with one requester's slot forced.
    function automatic logic [NREQ*CW-1:0] dur_with(input int slot, input int val);
        logic [NREQ*CW-1:0] d;
        d = NREQ*CW'($urandom);
        d[slot*CW +: CW] = CW'(val);
        return d;
    endfunction

    initial begin
        int exp_cnt [5];
        bit seen;
        logic [NREQ-1:0] r_cur;

        rst_n = 1'b0;
        req   = '0;
        dur   = '0;
        tick  = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_busy", 32'(busy), 32'd0);

        // Single request, dur=3, tick high: five granted cycles, pulse in the fifth
        exp_cnt = '{0, 1, 2, 3, 3};
        for (int c = 0; c < 5; c++) begin
            step(4'b0001, dur_with(0, 3), 1'b1);
            check("single_gnt",   32'(gnt),        32'h1);
            check("single_count", 32'(count),      32'(exp_cnt[c]));
            check("single_done",  32'(done_pulse), (c == 4) ? 32'h1 : 32'h0);
        end
        step(4'b0000, '0, 1'b1);
        check("single_idle_gnt", 32'(gnt), 32'h0);

        // Round robin with all requests held and zero durations
        do_reset();
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, '0, 1'($urandom));
            check("rr_gnt", 32'(gnt), 32'd1 << (g % NREQ));
            step(4'b1111, '0, 1'($urandom));
            check("rr_done", 32'(done_pulse), 32'd1 << (g % NREQ));
            step(4'b1111, '0, 1'($urandom));
        end

        // Tick gating: dur1=2, ticks 1,0,1,0 in RUN
        do_reset();
        step(4'b0010, dur_with(1, 2), 1'b0);
        exp_cnt = '{1, 1, 2, 2, 0};
        for (int c = 0; c < 4; c++) begin
            step(4'b0010, dur_with(1, 2), (c % 2) == 0);
            check("tick_count", 32'(count),      32'(exp_cnt[c]));
            check("tick_done",  32'(done_pulse), (c == 3) ? 32'h2 : 32'h0);
        end
        step(4'b0000, '0, 1'b0);

        // Owner drops its request mid-run
        do_reset();
        step(4'b0100, dur_with(2, 5), 1'b1);
        step(4'b0100, dur_with(2, 5), 1'b1);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step(4'b0000, '0, 1'b1);
            if (done_pulse[2]) seen = 1'b1;
        end
`ifdef TIMEOUT_SCHEDULER_ABORT_EN
        check("abort_no_pulse", 32'(seen), 32'd0);
`else
        check("abort_pulse_kept", 32'(seen), 32'd1);
`endif

        // Reset asserted mid-run at count==2
        do_reset();
        step(4'b0001, dur_with(0, 5), 1'b1);
        step(4'b0001, dur_with(0, 5), 1'b1);
        step(4'b0001, dur_with(0, 5), 1'b1);
        check("midrst_count_before", 32'(count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_gnt",   32'(gnt),        32'd0);
        check("midrst_count", 32'(count),      32'd0);
        check("midrst_busy",  32'(busy),       32'd0);
        check("midrst_done",  32'(done_pulse), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, '0, 1'b1);
        check("midrst_next_gnt", 32'(gnt), 32'h1);

        // Random traffic against the model
        do_reset();
        r_cur = '0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 4) == 0) r_cur = NREQ'($urandom);
            step(r_cur, NREQ*CW'($urandom), $urandom_range(0, 3) != 0);
            check("onehot_done", 32'($countones(done_pulse) <= 1), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
